db_fsm: RTL and testbench

//  Debounces a raw mechanical push-button/switch input into a clean level.

---
 rtl/db_fsm_pkg.sv | 24 ++
 rtl/db_fsm_if.sv | 9 +
 rtl/db_fsm_sync_2ff.sv | 26 ++
 rtl/db_fsm.sv | 95 +++++++++
 tb/tb_db_fsm.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/db_fsm_pkg.sv
// Shared definitions for the switch debouncer: state encodings, default
// qualification constants and output decode helpers.
package db_fsm_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  // 10 ms at 100 MHz
  localparam int unsigned STABLE_COUNT_DEF = 1_000_000;
  localparam int unsigned CNT_W_DEF        = 20;

  function automatic logic state_level(state_e s);
    return (s == ONE) || (s == WAIT0);
  endfunction

  function automatic logic state_busy(state_e s);
    return (s == WAIT1) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/db_fsm_if.sv
// Switch-side bundle of the debouncer: raw input in, clean level and busy out.
interface db_fsm_if;
  logic sw;
  logic db_level;
  logic busy;

  modport master (output sw, input  db_level, input  busy);
  modport slave  (input  sw, output db_level, output busy);
endinterface

// File: rtl/db_fsm_sync_2ff.sv
// Two-stage synchronizer for asynchronous inputs; both stages clear on reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/db_fsm.sv
// Push-button debouncer: synchronizes sw, then accepts a new level only after
// it has been seen unbroken for STABLE_COUNT cycles beyond the first sample.
module db_fsm
  import db_fsm_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  db_fsm_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_level_q;
  logic             busy_q;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sw),
    .q     (s2)
  );

  // A sample opposite to the run being qualified drops back to the old
  // stable state and discards the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ZERO: begin
        if (s2) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s2) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!s2) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s2) begin
          state_d = ONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they always equal the
  // Moore decode of state_q with no path from sw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ZERO;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= state_level(state_d);
      busy_q     <= state_busy(state_d);
    end
  end

  assign bus.db_level = db_level_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_db_fsm.sv
// Directed bench for db_fsm with a run-length reference model checked every cycle.
module tb_db_fsm;

  localparam int SC = 4;

  logic clk;
  logic reset;
  logic sw;

  db_fsm_if bus();
  assign bus.sw = sw;

  db_fsm #(.STABLE_COUNT(SC), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int ticks = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the accepted level flips once SC+1 consecutive synchronized
  // samples disagree with it; busy means such a run is in progress.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0;
  int   m_run = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0;
    end else begin
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == SC + 1) begin
          m_lvl = ~m_lvl;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  logic prev_lvl = 1'b0;
  always @(negedge clk) begin
    chk("model_level", int'(bus.db_level), int'(m_lvl));
    chk("model_busy",  int'(bus.busy),     int'(m_run > 0));
    if (bus.db_level && !prev_lvl) ticks++;
    prev_lvl = bus.db_level;
  end

  task automatic wait_lvl(input logic v, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.db_level !== v && n < maxc);
  endtask

  int n, nb, t0;
  logic [3:0] bounce;

  initial begin
    sw = 1'b0;
    reset = 1'b1;

    // reset held with sw high, then qualification after release
    sw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_level", int'(bus.db_level), 0);
      chk("rst_busy",  int'(bus.busy), 0);
    end
    reset = 1'b0;
    wait_lvl(1'b1, 20, n);
    chk("t1_rise_latency", n, 7);
    sw = 1'b0;
    wait_lvl(1'b0, 20, n);
    chk("t1_fall_latency", n, 7);
    repeat (3) @(negedge clk);

    // clean press
    t0 = ticks;
    nb = 0;
    sw = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) nb++;
    end
    chk("t2_busy_cycles", nb, 4);
    chk("t2_level", int'(bus.db_level), 1);
    chk("t2_ticks", ticks - t0, 1);
    sw = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_released", int'(bus.db_level), 0);

    // bounce on press
    bounce = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      sw = bounce[i];
      repeat (2) @(negedge clk);
      chk("t3_bounce_level", int'(bus.db_level), 0);
    end
    sw = 1'b1;
    wait_lvl(1'b1, 20, n);
    chk("t3_rise_latency", n, 7);
    sw = 1'b0;
    repeat (12) @(negedge clk);

    // short glitch while ZERO
    sw = 1'b1;
    repeat (3) @(negedge clk);
    sw = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_level", int'(bus.db_level), 0);
    chk("t4_busy",  int'(bus.busy), 0);

    // release bounce from ONE
    sw = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_in_one", int'(bus.db_level), 1);
    sw = 1'b0;
    @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    wait_lvl(1'b0, 20, n);
    chk("t5_fall_latency", n, 7);
    repeat (3) @(negedge clk);

    // async reset in the middle of WAIT1
    sw = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_busy_before", int'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy_in_reset",  int'(bus.busy), 0);
    chk("t6_level_in_reset", int'(bus.db_level), 0);
    #1 reset = 1'b0;
    wait_lvl(1'b1, 20, n);
    chk("t6_requalify", n, 7);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
